// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and helpers for the parametrised FIFO
package fifo_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_ADDR_W = 9;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port array, one write port, async read port
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Storage has no reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with FWFT/registered read
module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int AFULL_TH  = (2**ADDR_W) - 4,
  parameter int AEMPTY_TH = 4,
  parameter bit FWFT      = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic [WIDTH-1:0]  D,
  input  logic              WR,
  input  logic              RD,
  output logic [WIDTH-1:0]  Q,
  output logic              VALID,
  output logic              FULL,
  output logic              EMPTY,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic [ADDR_W:0]   CNT,
  output logic              OVF,
  output logic              UDF
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_param: AFULL_TH must lie in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad_aempty
    $error("fifo_param: AEMPTY_TH must lie in 0..DEPTH-1");
  end
  if (CNT_W != ADDR_W + 1) begin : g_bad_cnt
    $error("fifo_param: count width inconsistent with ADDR_W");
  end

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   cnt;
  logic              ovf, udf;
  logic              rd_ok, wr_ok, flush;
  logic [WIDTH-1:0]  ram_q;

  assign flush = RST | CLR;
  assign EMPTY  = (cnt == '0);
  assign FULL   = (cnt == DEPTH_C);
  assign AFULL  = (cnt >= AFULL_C);
  assign AEMPTY = (cnt <= AEMPTY_C);
  assign CNT    = cnt;
  assign OVF    = ovf;
  assign UDF    = udf;

  // A write into a full FIFO is still taken when a read frees a slot this cycle.
  assign rd_ok = RD & ~EMPTY;
  assign wr_ok = WR & (~FULL | rd_ok);

  fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_ok & ~flush),
    .waddr (wptr),
    .wdata (D),
    .raddr (rptr),
    .rdata (ram_q)
  );

  // Pointers, occupancy and sticky error flags; flush wins over any request.
  always_ff @(posedge CLK) begin
    if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + ADDR_W'(1);
      if (rd_ok) rptr <= rptr + ADDR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
        default: cnt <= cnt;
      endcase
      if (WR & ~wr_ok) ovf <= 1'b1;
      if (RD & EMPTY)  udf <= 1'b1;
    end
  end

  if (FWFT) begin : g_fwft
    assign Q     = ram_q;
    assign VALID = ~EMPTY;
  end else begin : g_reg
    logic [WIDTH-1:0] q_r;
    logic             valid_r;

    // Registered read: capture the head word on an accepted read, pulse VALID.
    always_ff @(posedge CLK) begin
      if (flush) begin
        q_r     <= '0;
        valid_r <= 1'b0;
      end else begin
        valid_r <= rd_ok;
        if (rd_ok) q_r <= ram_q;
      end
    end

    assign Q     = q_r;
    assign VALID = valid_r;
  end

endmodule
